// File: rtl/wtm_seq_8x8_ctrl.sv
// Unsigned 8x8 multiply sequenced over four cycles through one shared 4x4 multiplier.
// Valid/ready on both sides; one operation in flight at a time.
module wtm_seq_8x8_ctrl #(
  parameter int unsigned ZERO_SKIP = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [3:0]       mult_a,
  output logic [3:0]       mult_b,
  input  logic [7:0]       mult_p
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       step_q;
  logic [7:0]       a_q, b_q;
  logic [15:0]      acc_q, result_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] op_count_q;

  logic        accept, zero_op, handshake;
  logic [15:0] term, sum;

  assign accept    = in_valid && (state_q == StIdle);
  assign zero_op   = (ZERO_SKIP != 0) && ((in_a == 8'h00) || (in_b == 8'h00));
  // out_valid_q is only ever set while in DONE, so no state qualifier is needed
  assign handshake = out_valid_q && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = zero_op ? StDone : StCalc;
      StCalc: if (step_q == 2'd3) state_d = StDone;
      StDone: if (handshake) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the shared multiplier sees zeros outside CALC
  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    mult_a   = 4'd0;
    mult_b   = 4'd0;
    if (state_q == StCalc) begin
      mult_a = step_q[0] ? a_q[7:4] : a_q[3:0];
      mult_b = step_q[1] ? b_q[7:4] : b_q[3:0];
    end
  end

  // Partial product weight follows the nibble positions selected above
  always_comb begin
    term = 16'd0;
    unique case (step_q)
      2'd0:    term = {8'd0, mult_p};
      2'd1:    term = {4'd0, mult_p, 4'd0};
      2'd2:    term = {4'd0, mult_p, 4'd0};
      default: term = {mult_p, 8'd0};
    endcase
  end

  assign sum = acc_q + term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q      <= 2'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc_q       <= 16'd0;
      result_q    <= 16'd0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (accept) begin
        a_q    <= in_a;
        b_q    <= in_b;
        acc_q  <= 16'd0;
        step_q <= 2'd0;
        if (zero_op) begin
          result_q    <= 16'd0;
          out_valid_q <= 1'b1;
        end
      end
      if (state_q == StCalc) begin
        acc_q  <= sum;
        step_q <= step_q + 2'd1;
        if (step_q == 2'd3) begin
          result_q    <= sum;
          out_valid_q <= 1'b1;
        end
      end
      if (handshake) begin
        out_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 1'b1;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

endmodule
